// File: rtl/fifo_rr_enq_arbiter.sv
// Round-robin enqueue arbiter for one shared downstream FIFO, with burst locking:
// a requester that starts a multi-beat packet owns the FIFO until its last beat.
module fifo_rr_enq_arbiter #(
  parameter int width = 32,
  parameter int n     = 4,
  parameter int idxw  = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic [n-1:0]       REQ_ENQ,
  input  logic [n-1:0]       REQ_LAST,
  input  logic [n*width-1:0] REQ_DATA,
  output logic [n-1:0]       REQ_GRANT,
  input  logic               FIFO_FULL_N,
  output logic               FIFO_ENQ,
  output logic [width-1:0]   FIFO_D_IN,
  output logic               LOCKED,
  output logic [idxw-1:0]    OWNER
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [idxw-1:0] owner_q, owner_d;
  logic [idxw-1:0] ptr_q, ptr_d;
  logic [idxw-1:0] win, sel;
  logic [idxw:0]   j;
  logic            found, grant_ok;

  // Winner: the lock owner, else the first requester at or after ptr (mod n).
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = '0;
    if (state_q == BUSY) begin
      win   = owner_q;
      found = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        j = {1'b0, ptr_q} + (idxw+1)'(k);
        if (j >= (idxw+1)'(n)) j = j - (idxw+1)'(n);
        if (!found && REQ_ENQ[j[idxw-1:0]]) begin
          win   = j[idxw-1:0];
          found = 1'b1;
        end
      end
    end
    grant_ok = found && FIFO_FULL_N && RST;
  end

  assign REQ_GRANT = grant_ok ? (n'(1) << win) : '0;
  assign FIFO_ENQ  = |(REQ_ENQ & REQ_GRANT);
  assign sel       = FIFO_ENQ ? win : '0;
  assign FIFO_D_IN = REQ_DATA[sel*width +: width];
  assign LOCKED    = (state_q == BUSY);
  assign OWNER     = owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (CLR) begin
      state_d = IDLE;
      owner_d = '0;
      ptr_d   = '0;
    end else if (FIFO_ENQ) begin
      if (REQ_LAST[win]) begin
        state_d = IDLE;
        ptr_d   = (win == idxw'(n-1)) ? '0 : win + 1'b1;
      end else begin
        state_d = BUSY;
        owner_d = win;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_enq_arbiter.sv
// Bench for fifo_rr_enq_arbiter: directed scenarios with literal grants, then random
// packets into a 2-deep FIFO model with per-requester in-order checking.
module tb_fifo_rr_enq_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           CLK = 1'b0;
  logic           RST, CLR;
  logic [N-1:0]   REQ_ENQ, REQ_LAST, REQ_GRANT;
  logic [N*W-1:0] REQ_DATA;
  logic           FIFO_FULL_N, FIFO_ENQ;
  logic [W-1:0]   FIFO_D_IN;
  logic           LOCKED;
  logic [IW-1:0]  OWNER;

  fifo_rr_enq_arbiter #(.width(W), .n(N), .idxw(IW)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .REQ_ENQ(REQ_ENQ), .REQ_LAST(REQ_LAST), .REQ_DATA(REQ_DATA),
    .REQ_GRANT(REQ_GRANT), .FIFO_FULL_N(FIFO_FULL_N), .FIFO_ENQ(FIFO_ENQ),
    .FIFO_D_IN(FIFO_D_IN), .LOCKED(LOCKED), .OWNER(OWNER)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  int m_lock, m_owner, m_ptr;
  int last_w;
  bit sb_on = 0;
  logic [W-1:0] q[$];
  int pushed = 0, popped = 0;

  // Reference: which requester the rules say is granted right now (-1 = none).
  function automatic int exp_win();
    if (!RST || !FIFO_FULL_N) return -1;
    if (m_lock != 0) return m_owner;
    for (int k = 0; k < N; k++)
      if (REQ_ENQ[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int w;
    logic [N-1:0] g;
    logic e;
    w = exp_win();
    g = (w >= 0) ? N'(1) << w : '0;
    e = (w >= 0) && REQ_ENQ[w];
    chk("grant", 64'(REQ_GRANT), 64'(g));
    chk("enq", 64'(FIFO_ENQ), 64'(e));
    if (e) chk("d_in", 64'(FIFO_D_IN), 64'(REQ_DATA[w*W +: W]));
    chk("locked", 64'(LOCKED), 64'(RST && m_lock != 0));
    if (!RST || m_lock != 0) chk("owner", 64'(OWNER), RST ? 64'(m_owner) : 64'(0));
  endtask

  task automatic update_model();
    int w;
    w = exp_win();
    last_w = -1;
    if (!RST) begin
      m_lock = 0; m_owner = 0; m_ptr = 0;
      return;
    end
    if (w >= 0 && REQ_ENQ[w]) begin
      last_w = w;
      if (sb_on) begin q.push_back(REQ_DATA[w*W +: W]); pushed++; end
      if (!CLR) begin
        if (REQ_LAST[w]) begin m_lock = 0; m_ptr = (w + 1) % N; end
        else begin m_lock = 1; m_owner = w; end
      end
    end
    if (CLR) begin m_lock = 0; m_owner = 0; m_ptr = 0; end
  endtask

  // One cycle: compare at negedge (with optional literal grant/locked), advance model at posedge.
  task automatic tick(input int glit = -1, input int llit = -1);
    @(negedge CLK);
    check_all();
    if (glit >= 0) chk("lit_grant", 64'(REQ_GRANT), 64'(glit));
    if (llit >= 0) chk("lit_locked", 64'(LOCKED), 64'(llit));
    @(posedge CLK);
    update_model();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] e, input logic [N-1:0] l);
    REQ_ENQ = e;
    REQ_LAST = l;
    for (int i = 0; i < N; i++) REQ_DATA[i*W +: W] = {8'(i), 8'hA5, 16'($urandom)};
  endtask

  int rem[N], seq[N], exp_seq[N];

  initial begin
    m_lock = 0; m_owner = 0; m_ptr = 0;
    RST = 1'b0; CLR = 1'b0; FIFO_FULL_N = 1'b1;
    drive('0, '0);
    #1;
    chk("reset_grant", 64'(REQ_GRANT), 64'(0));
    chk("reset_owner", 64'(OWNER), 64'(0));
    drive(4'b1111, 4'b1111);
    tick(0, 0);
    tick(0, 0);
    RST = 1'b1;

    // Round robin over all-ready single-beat packets
    for (int c = 0; c < 8; c++) begin drive(4'b1111, 4'b1111); tick(1 << (c % 4), 0); end

    // Burst lock: req1 holds 3 beats, then req3, then req0
    drive(4'b0001, 4'b1111); tick(4'b0001, 0);
    drive(4'b1011, 4'b1001); tick(4'b0010, 0);
    drive(4'b1011, 4'b1001); tick(4'b0010, 1);
    drive(4'b1011, 4'b1011); tick(4'b0010, 1);
    drive(4'b1011, 4'b1011); tick(4'b1000, 0);
    drive(4'b1011, 4'b1011); tick(4'b0001, 0);

    // Backpressure holds ptr; req0 wins once space returns
    drive(4'b1000, 4'b1111); tick(4'b1000, 0);
    FIFO_FULL_N = 1'b0;
    for (int c = 0; c < 5; c++) begin drive(4'b0011, 4'b0011); tick(0, 0); end
    FIFO_FULL_N = 1'b1;
    drive(4'b0011, 4'b0011); tick(4'b0001, 0);

    // Locked owner idle blocks everyone
    drive(4'b0001, 4'b0000); tick(4'b0001, 0);
    for (int c = 0; c < 3; c++) begin drive(4'b1110, 4'b1110); tick(4'b0001, 1); end
    drive(4'b0001, 4'b0001); tick(4'b0001, 1);

    // CLR during lock: beat still enqueues, lock and ptr clear
    drive(4'b1000, 4'b0000); tick(4'b1000, 0);
    CLR = 1'b1;
    drive(4'b1000, 4'b0000); tick(4'b1000, 1);
    CLR = 1'b0;
    drive(4'b0011, 4'b0011); tick(4'b0001, 0);

    // Reset mid-packet
    drive(4'b0100, 4'b0000); tick(4'b0100, 0);
    drive(4'b0100, 4'b0000);
    #2 RST = 1'b0;
    #1;
    chk("midrst_grant", 64'(REQ_GRANT), 64'(0));
    chk("midrst_locked", 64'(LOCKED), 64'(0));
    tick(0, 0);
    RST = 1'b1;
    drive(4'b0101, 4'b0101); tick(4'b0001, 0);
    drive(4'b0100, 4'b0100); tick(4'b0100, 0);

    // Random packets into a 2-deep FIFO with random drain
    sb_on = 1;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; exp_seq[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(3) == 0) rem[i] = 1 + $urandom_range(3);
        REQ_ENQ[i]  = (rem[i] > 0) && ($urandom_range(3) != 0);
        REQ_LAST[i] = (rem[i] == 1);
        REQ_DATA[i*W +: W] = {8'(i), 24'(seq[i])};
      end
      CLR = ($urandom_range(49) == 0);
      FIFO_FULL_N = (q.size() < 2);
      tick();
      if (last_w >= 0) begin seq[last_w]++; rem[last_w]--; end
      if (q.size() > 0 && $urandom_range(1) == 0) begin
        logic [W-1:0] d;
        int id;
        d = q.pop_front();
        popped++;
        id = int'(d[31:24]);
        if (id < N) begin
          chk("order", 64'(d[23:0]), 64'(exp_seq[id]));
          exp_seq[id]++;
        end else chk("bad_id", 64'(id), 64'(0));
      end
    end
    CLR = 1'b0;
    while (q.size() > 0) begin
      logic [W-1:0] d;
      d = q.pop_front();
      popped++;
      if (int'(d[31:24]) < N) begin
        chk("order_drain", 64'(d[23:0]), 64'(exp_seq[d[31:24]]));
        exp_seq[d[31:24]]++;
      end
    end
    for (int i = 0; i < N; i++) chk("no_loss", 64'(exp_seq[i]), 64'(seq[i]));
    chk("pushed_popped", 64'(popped), 64'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
